// File: rtl/fwd_hazard_unit.sv
// Forwarding unit: EXEC..WB destination scoreboard with EXEC operand selects and load-use stall.
// Optional FWD_ZERO_REG_EN: register tag 0 is hard-wired zero and never forwards or stalls.
module fwd_hazard_unit #(
  parameter int REG_AW     = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [SELW-1:0]   ex_sel1,
  output logic [SELW-1:0]   ex_sel2,
  output logic [15:0]       stall_cnt
);

`ifdef FWD_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb;
    logic              load;
  } ent_t;

  ent_t              s [DEPTH];
  logic [REG_AW-1:0] ex_src1;
  logic [REG_AW-1:0] ex_src2;
  logic              st1;
  logic              st2;

  function automatic logic hit(ent_t e, logic [REG_AW-1:0] r);
    hit = e.valid && e.wb && (e.dest == r)
          && !(ZERO_REG && (e.dest == '0));
  endfunction

  // EXEC operand selects: lowest matching stage (youngest producer) wins
  always_comb begin
    ex_sel1 = '0;
    ex_sel2 = '0;
    if (s[0].valid) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (hit(s[k], ex_src1)) ex_sel1 = SELW'(k);
        if (hit(s[k], ex_src2)) ex_sel2 = SELW'(k);
      end
    end
  end

  // Load-use stall: youngest producer per source decides, loads too young stall
  always_comb begin
    st1 = 1'b0;
    st2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit(s[k], id_src1))
        st1 = s[k].load && (k + 1 < LOAD_STAGE);
      if (hit(s[k], id_src2))
        st2 = s[k].load && (k + 1 < LOAD_STAGE);
    end
    stall = !rst && id_valid && !flush && (st1 || st2);
  end

  // Scoreboard shift, EXEC capture/bubble and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
      ex_src1   <= '0;
      ex_src2   <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
      if (!stall && !flush) begin
        s[0]    <= '{valid: id_valid, dest: id_dest,
                     wb: id_wb, load: id_load};
        ex_src1 <= id_src1;
        ex_src2 <= id_src2;
      end else begin
        s[0] <= '0;
      end
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised next-generation forwarding unit for the pipelined core.
- Keeps its own scoreboard of in-flight destination tags for EXEC through WB, so the stage tags no longer have to be routed back to it.
- Generates the EXEC operand-forwarding selects and the load-use stall for the decode stage.
- Sits between ID and EXEC and drives the EXEC operand muxes and the ID/IF hold/bubble control.

Parameters:
- REG_AW, 2: register-address width. Register tags are REG_AW bits.
- DEPTH, 3: tracked stages, index 0 = EXEC up to DEPTH-1 = WB. Minimum 2.
- LOAD_STAGE, 2: lowest stage index at which load data can be forwarded. Range 1..DEPTH-1.
- SELW, clog2(DEPTH): forwarding-select width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_src1  in  REG_AW  decode source register 1
- id_src2  in  REG_AW  decode source register 2
- id_dest  in  REG_AW  decode destination register
- id_wb  in  1  decode instruction writes back
- id_load  in  1  decode instruction is a load
- flush  in  1  kill the instruction entering EXEC
- stall  out  1  hold IF/ID and insert a bubble into EXEC
- ex_sel1  out  SELW  EXEC operand-1 mux select
- ex_sel2  out  SELW  EXEC operand-2 mux select
- stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Stage array S[0..DEPTH-1]. Each entry holds {valid, dest, wb, load}. The EXEC entry S[0] also holds src1/src2.
- Shift, every cycle:
  - S[i] <= S[i-1] for i >= 1.
  - S[DEPTH-1] retires.
  - S[0] <= ID fields (valid = id_valid) when stall=0 and flush=0; otherwise S[0] <= invalid bubble.
  - The pipeline downstream of EXEC never stalls.
- Producer match for stage k: S[k].valid and S[k].wb and S[k].dest == src.
- ex_sel1/ex_sel2 (combinational from S[0] and S[1..DEPTH-1]):
  - value k (1..DEPTH-1) selects the youngest matching S[k]; lowest k wins.
  - 0 = register file when there is no match or S[0] is invalid.
  - With DEPTH=3: 01 = MEM, 10 = WB.
- stall (combinational): asserted when id_valid=1 and some valid load S[j] matches id_src1 or id_src2 with j+1 < LOAD_STAGE.
  - Only the youngest match per source counts. A younger non-load producer of the same register shadows an older load, so no stall.
  - stall is not asserted while flush=1.
- Default timing: a load in EXEC followed by a dependent instruction gives exactly 1 stall cycle. On the next cycle the select is k=2 (WB).
- stall_cnt increments on each cycle stall=1 and saturates at 16'hFFFF.
- flush has priority over the ID capture. S[1..] still shift normally.
- Reset (synchronous, active-high): all S entries invalid; ex_sel1 = ex_sel2 = 0; stall = 0; stall_cnt = 0. Reset mid-stall cancels the stall on the next cycle.
- Source equal to destination on the same instruction is ignored; only older stages are compared.

Optional Feature:
- Macro: FWD_ZERO_REG_EN.
- When defined: register tag 0 is hard-wired zero. An entry with dest == 0 never matches, so tag 0 never forwards and never stalls.
- When undefined: tag 0 is an ordinary register.

Test Plan:
- Reset held 2 cycles -> stall=0, ex_sel1=ex_sel2=0, stall_cnt=0. Then release and issue ADD r1 (wb=1); next cycle issue SUB r2 <- r1,r3 -> ex_sel1=01, ex_sel2=00 while SUB is in EXEC.
- ADD r1; NOP; SUB r2 <- r3,r1 -> ex_sel2=10 (WB) when SUB reaches EXEC.
- ADD r1; ADD r1; SUB src1=r1 -> ex_sel1=01: the youngest producer wins.
- LOAD r2; dependent ADD src2=r2 -> stall=1 for exactly 1 cycle with a bubble in S[0]; then ADD in EXEC gets ex_sel2=10; stall_cnt=1.
- LOAD r2 in EXEC and flush=1 on the ADD's issue cycle -> S[0] invalid next cycle, ex_sel1=ex_sel2=0. A separate flush asserted with a dependent ADD in ID -> stall=0 in that cycle.
- With FWD_ZERO_REG_EN defined: ADD r0; SUB src1=r0 -> ex_sel1=00. With the macro undefined the same sequence -> 01.
